muldiv_unit: RTL

//  Iterative integer multiply/divide unit in the execute stage, downstream of the instruction decoder.

---
 rtl/muldiv_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add MUL, restoring DIV/REM, one bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish the cycle after accept.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_func,
  input  logic            in_sign,
  input  logic            in_cut,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  // W-form results are always the low word sign-extended, regardless of in_sign
  function automatic logic [XLEN-1:0] fit(input logic c, input logic [XLEN-1:0] v);
    return c ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  logic [XLEN-1:0] a_p, b_p, mag_a, mag_b, min_val, fast_res;
  logic            a_neg, b_neg, is_div, is_rem, div_zero, ovf, fast, accept;

  always_comb begin
    a_p      = in_a;
    b_p      = in_b;
    if (in_cut) begin
      a_p = {{(XLEN-32){in_sign & in_a[31]}}, in_a[31:0]};
      b_p = {{(XLEN-32){in_sign & in_b[31]}}, in_b[31:0]};
    end
    is_div   = (in_func == 2'b01) || (in_func == 2'b10);
    is_rem   = (in_func == 2'b10);
    a_neg    = in_sign & a_p[XLEN-1];
    b_neg    = in_sign & b_p[XLEN-1];
    mag_a    = a_neg ? -a_p : a_p;
    mag_b    = b_neg ? -b_p : b_p;
    min_val  = in_cut ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_p == '0);
    ovf      = in_sign && (a_p == min_val) && (b_p == '1);
    fast     = is_div && (div_zero || ovf);
    if (div_zero) fast_res = is_rem ? a_p : '1;
    else          fast_res = is_rem ? '0  : a_p;
    accept   = in_valid && (state == IDLE) && !flush;
  end

  // acc: product / remainder; sa: multiplicand / dividend-then-quotient; sb: multiplier / divisor
  logic [XLEN-1:0] acc, sa, sb, nxt_acc, nxt_sa, nxt_sb, raw;
  logic [CW-1:0]   cnt;
  logic            div_r, rem_r, cut_r, neg_q, neg_r;
  logic [XLEN:0]   t;
  logic            ge;

  // working remainder is XLEN+1 bits: shifted remainder plus next dividend bit
  always_comb begin
    nxt_acc = acc;
    nxt_sa  = sa;
    nxt_sb  = sb;
    t       = {acc, sa[XLEN-1]};
    ge      = (t >= {1'b0, sb});
    if (div_r) begin
      nxt_acc = ge ? XLEN'(t - {1'b0, sb}) : t[XLEN-1:0];
      nxt_sa  = {sa[XLEN-2:0], ge};
    end else begin
      if (sb[0]) nxt_acc = acc + sa;
      nxt_sa = sa << 1;
      nxt_sb = sb >> 1;
    end
    if (rem_r)      raw = neg_r ? -nxt_acc : nxt_acc;
    else if (div_r) raw = neg_q ? -nxt_sa  : nxt_sa;
    else            raw = nxt_acc;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0; sa <= '0; sb <= '0; cnt <= '0;
      div_r <= 1'b0; rem_r <= 1'b0; cut_r <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
      out_result <= '0;
    end else if (accept) begin
      div_r <= is_div;
      rem_r <= is_rem;
      cut_r <= in_cut;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      acc   <= '0;
      cnt   <= in_cut ? CW'(31) : CW'(XLEN-1);
      if (is_div) begin
        // left-align the dividend so its MSB shifts out first for either width
        sa <= in_cut ? (mag_a << (XLEN-32)) : mag_a;
        sb <= mag_b;
      end else begin
        sa <= a_p;
        sb <= b_p;
      end
      if (fast) out_result <= fit(in_cut, fast_res);
    end else if (state == BUSY && !flush) begin
      acc <= nxt_acc;
      sa  <= nxt_sa;
      sb  <= nxt_sb;
      cnt <= cnt - 1'b1;
      if (cnt == '0) out_result <= fit(cut_r, raw);
    end
  end
endmodule
